pcpu: RTL and testbench

//  5-stage in-order pipelined MIPS-subset CPU (IF/ID/EX/MEM/WB), Harvard interface.

---
 rtl/pcpu.sv | 241 ++++++++++++++++++++++++
 tb/tb_pcpu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpu.sv
// pcpu: 5-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with Harvard memory ports.
// Latency: one instruction per clk; taken branch/jump costs 2 bubbles, load-use costs 1 bubble.
// Backpressure: none external; a load-use hazard holds PC and IF/ID for one cycle.
module pcpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_mem,
  output logic [31:0] data_addr,
  input  logic [31:0] data_mem,
  output logic        data_we,
  output logic [31:0] data_write
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_PASSB
  } alu_op_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        vld;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        reg_we;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rs_dat;
    logic [31:0] rt_dat;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [25:0] jaddr;
  } idex_t;

  typedef struct packed {
    logic        reg_we;
    logic        is_lw;
    logic        is_sw;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] st_dat;
  } exmem_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  dst;
    logic [31:0] wb_dat;
  } memwb_t;

  logic [31:0] pc;
  ifid_t       ifid;
  idex_t       idex, dec;
  exmem_t      exmem, ex_nxt;
  memwb_t      memwb;
  logic [31:0] rf [32];

  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic [31:0] rf_rs_dat, rf_rt_dat;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res, br_target;
  logic        redirect, stall;

  assign id_op     = ifid.instr[31:26];
  assign id_rs     = ifid.instr[25:21];
  assign id_rt     = ifid.instr[20:16];
  assign id_rd     = ifid.instr[15:11];
  assign id_funct  = ifid.instr[5:0];
  assign id_imm    = ifid.instr[15:0];

  // Register read with WB bypass so a same-cycle write is visible in ID; $0 always reads 0
  always_comb begin
    rf_rs_dat = rf[id_rs];
    rf_rt_dat = rf[id_rt];
    if (memwb.reg_we && memwb.dst == id_rs) rf_rs_dat = memwb.wb_dat;
    if (memwb.reg_we && memwb.dst == id_rt) rf_rt_dat = memwb.wb_dat;
    if (id_rs == 5'd0) rf_rs_dat = '0;
    if (id_rt == 5'd0) rf_rt_dat = '0;
  end

  // Decode the IF/ID word into ID/EX controls; unknown encodings decode to a write-free NOP
  always_comb begin
    dec        = '0;
    dec.vld    = ifid.vld;
    dec.rs     = id_rs;
    dec.rt     = id_rt;
    dec.dst    = id_rt;
    dec.rs_dat = rf_rs_dat;
    dec.rt_dat = rf_rt_dat;
    dec.imm    = {{16{id_imm[15]}}, id_imm};
    dec.pc4    = ifid.pc4;
    dec.jaddr  = ifid.instr[25:0];
    if (ifid.vld) begin
      case (id_op)
        6'h00: begin
          dec.dst    = id_rd;
          dec.reg_we = 1'b1;
          case (id_funct)
            6'h20:   dec.alu_op = ALU_ADD;
            6'h22:   dec.alu_op = ALU_SUB;
            6'h24:   dec.alu_op = ALU_AND;
            6'h25:   dec.alu_op = ALU_OR;
            6'h2A:   dec.alu_op = ALU_SLT;
            default: dec.reg_we = 1'b0;
          endcase
        end
        6'h08: begin dec.use_imm = 1'b1; dec.reg_we = 1'b1; dec.alu_op = ALU_ADD; end
        6'h0C: begin
          dec.use_imm = 1'b1; dec.reg_we = 1'b1; dec.alu_op = ALU_AND;
          dec.imm     = {16'h0, id_imm};
        end
        6'h0D: begin
          dec.use_imm = 1'b1; dec.reg_we = 1'b1; dec.alu_op = ALU_OR;
          dec.imm     = {16'h0, id_imm};
        end
        6'h0F: begin
          dec.use_imm = 1'b1; dec.reg_we = 1'b1; dec.alu_op = ALU_PASSB;
          dec.imm     = {id_imm, 16'h0};
        end
        6'h23: begin dec.use_imm = 1'b1; dec.reg_we = 1'b1; dec.is_lw = 1'b1; end
        6'h2B: begin dec.use_imm = 1'b1; dec.is_sw = 1'b1; end
        6'h04: dec.is_beq = 1'b1;
        6'h05: dec.is_bne = 1'b1;
        6'h02: dec.is_j   = 1'b1;
        default: ;
      endcase
    end
  end

  // A load in EX feeding either source of the ID instruction must wait one cycle for MEM data
  assign stall = idex.vld && idex.is_lw && ifid.vld &&
                 ((idex.dst == id_rs) || (idex.dst == id_rt));

  // EX operand forwarding: the younger EX/MEM result beats MEM/WB; $0 is never forwarded
  always_comb begin
    fwd_a = idex.rs_dat;
    fwd_b = idex.rt_dat;
    if (memwb.reg_we && memwb.dst != 5'd0 && memwb.dst == idex.rs) fwd_a = memwb.wb_dat;
    if (memwb.reg_we && memwb.dst != 5'd0 && memwb.dst == idex.rt) fwd_b = memwb.wb_dat;
    if (exmem.reg_we && exmem.dst != 5'd0 && exmem.dst == idex.rs) fwd_a = exmem.alu;
    if (exmem.reg_we && exmem.dst != 5'd0 && exmem.dst == idex.rt) fwd_b = exmem.alu;
  end

  assign alu_b = idex.use_imm ? idex.imm : fwd_b;

  // ALU, branch resolution and EX/MEM next-state
  always_comb begin
    case (idex.alu_op)
      ALU_ADD:   alu_res = fwd_a + alu_b;
      ALU_SUB:   alu_res = fwd_a - alu_b;
      ALU_AND:   alu_res = fwd_a & alu_b;
      ALU_OR:    alu_res = fwd_a | alu_b;
      ALU_SLT:   alu_res = {31'b0, $signed(fwd_a) < $signed(alu_b)};
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase
    redirect  = idex.vld && (idex.is_j ||
                             (idex.is_beq && fwd_a == fwd_b) ||
                             (idex.is_bne && fwd_a != fwd_b));
    br_target = idex.is_j ? {idex.pc4[31:28], idex.jaddr, 2'b00}
                          : idex.pc4 + {idex.imm[29:0], 2'b00};
    ex_nxt        = '0;
    ex_nxt.reg_we = idex.vld && idex.reg_we;
    ex_nxt.is_lw  = idex.vld && idex.is_lw;
    ex_nxt.is_sw  = idex.vld && idex.is_sw;
    ex_nxt.dst    = idex.dst;
    ex_nxt.alu    = alu_res;
    ex_nxt.st_dat = fwd_b;
  end

  // PC: redirect beats stall; otherwise advance one word per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          pc <= RESET_PC;
    else if (redirect) pc <= br_target;
    else if (!stall)   pc <= pc + 32'd4;
  end

  // IF/ID: flushed on redirect, held on stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid <= '0;
    end else if (redirect) begin
      ifid <= '0;
    end else if (!stall) begin
      ifid.vld   <= 1'b1;
      ifid.pc4   <= pc + 32'd4;
      ifid.instr <= inst_mem;
    end
  end

  // ID/EX: bubble on redirect or stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  idex <= '0;
    else if (redirect || stall) idex <= '0;
    else                       idex <= dec;
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exmem <= '0;
    else      exmem <= ex_nxt;
  end

  // MEM/WB register: loads capture the combinational data memory word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memwb <= '0;
    end else begin
      memwb.reg_we <= exmem.reg_we;
      memwb.dst    <= exmem.dst;
      memwb.wb_dat <= exmem.is_lw ? data_mem : exmem.alu;
    end
  end

  // Register file write in WB; $0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (memwb.reg_we && memwb.dst != 5'd0) begin
      rf[memwb.dst] <= memwb.wb_dat;
    end
  end

  assign inst_addr  = pc;
  assign data_addr  = exmem.alu;
  assign data_write = exmem.st_dat;
  assign data_we    = exmem.is_sw;

endmodule

// File: tb/tb_pcpu.sv
// tb_pcpu: directed program table plus random programs checked against an ISA-level model.
// Observes the store stream (addr, data, cycle) and the fetch address per cycle.
// Memories are modelled in the bench; data memory writes on posedge when data_we.
module tb_pcpu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr, inst_mem, data_addr, data_mem, data_write;
  logic        data_we;

  pcpu #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_mem(inst_mem),
    .data_addr(data_addr), .data_mem(data_mem), .data_we(data_we), .data_write(data_write)
  );

  always #5 clk = ~clk;

  logic [31:0] imem  [0:255];
  logic [31:0] dmem  [0:63];
  logic [31:0] dinit [0:63];
  logic        dload = 1'b0;

  assign inst_mem = imem[inst_addr[9:2]];
  assign data_mem = dmem[data_addr[7:2]];

  always @(posedge clk) begin
    if (dload)        dmem <= dinit;
    else if (data_we) dmem[data_addr[7:2]] <= data_write;
  end

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] sa [$];
  logic [31:0] sd [$];
  logic [31:0] sc [$];
  logic [31:0] ia [0:255];
  logic [31:0] ea [$];
  logic [31:0] ed [$];
  logic [31:0] mr [0:31];
  logic [31:0] mm [0:63];

  typedef struct {
    string       name;
    int          prog;
    int          kind;   // 0 store count, 1 store addr, 2 store data, 3 store cycle, 4 fetch addr
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add_vec(input string name, input int prog, input int kind,
                         input int idx, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.prog = prog; v.kind = kind; v.idx = idx; v.exp = exp;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] addr);
    return {6'h02, addr};
  endfunction

  function automatic logic [31:0] get_act(input int kind, input int idx);
    case (kind)
      0: return 32'(sa.size());
      1: return (idx < sa.size()) ? sa[idx] : 32'hxxxx_xxxx;
      2: return (idx < sd.size()) ? sd[idx] : 32'hxxxx_xxxx;
      3: return (idx < sc.size()) ? sc[idx] : 32'hxxxx_xxxx;
      default: return ia[idx];
    endcase
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++) dinit[i] = 32'h0;
  endtask

  task automatic load_prog(input int p);
    clear_mem();
    case (p)
      0: begin
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd3);
        imem[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
        imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
      end
      1: begin
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd13);
        imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
        imem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
        imem[3] = enc_i(6'h08, 5'd4, 5'd5, 16'd1);
        imem[4] = enc_i(6'h2B, 5'd0, 5'd5, 16'd12);
      end
      2: begin
        imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        imem[1] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        imem[2] = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
        imem[3] = enc_i(6'h2B, 5'd0, 5'd6, 16'd16);
        imem[4] = enc_i(6'h2B, 5'd0, 5'd7, 16'd20);
      end
      3: begin
        imem[0] = enc_i(6'h0F, 5'd0, 5'd8, 16'h8000);
        imem[1] = enc_r(6'h2A, 5'd8, 5'd0, 5'd9);
        imem[2] = enc_i(6'h05, 5'd9, 5'd9, 16'd5);
        imem[3] = enc_i(6'h2B, 5'd0, 5'd9, 16'd24);
        imem[4] = enc_i(6'h2B, 5'd0, 5'd8, 16'd28);
        imem[5] = enc_j(26'd0);
        imem[6] = enc_i(6'h2B, 5'd0, 5'd9, 16'd32);
        imem[7] = enc_i(6'h2B, 5'd0, 5'd9, 16'd36);
      end
      default: begin
        imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        imem[1] = enc_i(6'h2B, 5'd0, 5'd0, 16'd4);
        imem[3] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
        imem[5] = enc_i(6'h2B, 5'd0, 5'd10, 16'd40);
      end
    endcase
  endtask

  // Reset, load data memory, release on a negedge; cycle k = k-th posedge after release
  task automatic run_prog(input int ncyc);
    rst = 1'b0;
    sa.delete(); sd.delete(); sc.delete();
    dload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dload = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ia[0] = inst_addr;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      ia[k] = inst_addr;
      if (data_we) begin
        sa.push_back(data_addr);
        sd.push_back(data_write);
        sc.push_back(32'(k));
      end
    end
  endtask

  task automatic gen_prog(input int n);
    logic [31:0] w, r;
    logic [4:0]  rs, rt, rd;
    int          kind, maxoff;
    clear_mem();
    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      dinit[i] = r;
      mm[i]    = r;
    end
    for (int i = 0; i < n; i++) begin
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 7));
      r    = $urandom;
      kind = int'($urandom_range(0, 13));
      maxoff = (n - 1 - i > 3) ? 3 : n - 1 - i;
      case (kind)
        0:  w = enc_r(6'h20, rs, rt, rd);
        1:  w = enc_r(6'h22, rs, rt, rd);
        2:  w = enc_r(6'h24, rs, rt, rd);
        3:  w = enc_r(6'h25, rs, rt, rd);
        4:  w = enc_r(6'h2A, rs, rt, rd);
        5:  w = enc_i(6'h08, rs, rt, r[15:0]);
        6:  w = enc_i(6'h0C, rs, rt, r[15:0]);
        7:  w = enc_i(6'h0D, rs, rt, r[15:0]);
        8:  w = enc_i(6'h0F, 5'd0, rt, r[15:0]);
        9:  w = enc_i(6'h23, rs, rt, {8'h0, r[7:0]});
        10: w = enc_i(6'h2B, rs, rt, {8'h0, r[7:0]});
        11: w = enc_i(6'h04, rs, rt, 16'($urandom_range(0, maxoff)));
        12: w = enc_i(6'h05, rs, rt, 16'($urandom_range(0, maxoff)));
        default: w = {6'h3F, r[25:0]};
      endcase
      imem[i] = w;
    end
    imem[n] = enc_j(26'(n));
  endtask

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion
  task automatic run_model(input int n);
    logic [31:0] w, a, b, simm, zimm, addr;
    logic [4:0]  rt, rd;
    int          pc_i, nxt, steps;
    ea.delete(); ed.delete();
    for (int i = 0; i < 32; i++) mr[i] = 32'h0;
    pc_i = 0; steps = 0;
    while (pc_i < n && steps < 1000) begin
      w    = imem[pc_i];
      a    = mr[w[25:21]];
      b    = mr[w[20:16]];
      rt   = w[20:16];
      rd   = w[15:11];
      simm = {{16{w[15]}}, w[15:0]};
      zimm = {16'h0, w[15:0]};
      addr = a + simm;
      nxt  = pc_i + 1;
      case (w[31:26])
        6'h00: if (rd != 5'd0) case (w[5:0])
          6'h20: mr[rd] = a + b;
          6'h22: mr[rd] = a - b;
          6'h24: mr[rd] = a & b;
          6'h25: mr[rd] = a | b;
          6'h2A: mr[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h08: if (rt != 5'd0) mr[rt] = a + simm;
        6'h0C: if (rt != 5'd0) mr[rt] = a & zimm;
        6'h0D: if (rt != 5'd0) mr[rt] = a | zimm;
        6'h0F: if (rt != 5'd0) mr[rt] = {w[15:0], 16'h0};
        6'h23: if (rt != 5'd0) mr[rt] = mm[addr[7:2]];
        6'h2B: begin
          ea.push_back(addr);
          ed.push_back(b);
          mm[addr[7:2]] = b;
        end
        6'h04: if (a == b) nxt = pc_i + 1 + int'($signed(w[15:0]));
        6'h05: if (a != b) nxt = pc_i + 1 + int'($signed(w[15:0]));
        default: ;
      endcase
      pc_i = nxt;
      steps++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;

    // Directed program table
    add_vec("alu_cnt",   0, 0, 0, 32'd1);
    add_vec("alu_addr",  0, 1, 0, 32'd0);
    add_vec("alu_data",  0, 2, 0, 32'd13);
    add_vec("alu_cyc",   0, 3, 0, 32'd6);
    add_vec("alu_ia1",   0, 4, 1, 32'd4);
    add_vec("alu_ia3",   0, 4, 3, 32'd12);
    add_vec("lu_cnt",    1, 0, 0, 32'd2);
    add_vec("lu_data0",  1, 2, 0, 32'd13);
    add_vec("lu_addr1",  1, 1, 1, 32'd12);
    add_vec("lu_data1",  1, 2, 1, 32'd14);
    add_vec("lu_cyc1",   1, 3, 1, 32'd8);
    add_vec("lu_ia5",    1, 4, 5, 32'd16);
    add_vec("lu_ia6",    1, 4, 6, 32'd20);
    add_vec("br_cnt",    2, 0, 0, 32'd2);
    add_vec("br_addr0",  2, 1, 0, 32'd16);
    add_vec("br_data6",  2, 2, 0, 32'd0);
    add_vec("br_data7",  2, 2, 1, 32'd0);
    add_vec("br_cyc0",   2, 3, 0, 32'd6);
    add_vec("j_cnt",     3, 0, 0, 32'd4);
    add_vec("slt_data",  3, 2, 0, 32'd1);
    add_vec("lui_data",  3, 2, 1, 32'h8000_0000);
    add_vec("j_cyc2",    3, 3, 2, 32'd14);
    add_vec("j_ia7",     3, 4, 7, 32'd28);
    add_vec("j_ia8",     3, 4, 8, 32'd0);
    add_vec("j_ia9",     3, 4, 9, 32'd4);
    add_vec("z_cnt",     4, 0, 0, 32'd2);
    add_vec("z_addr0",   4, 1, 0, 32'd4);
    add_vec("z_data0",   4, 2, 0, 32'd0);
    add_vec("z_data1",   4, 2, 1, 32'd9);
    add_vec("z_cyc1",    4, 3, 1, 32'd8);

    for (int p = 0; p < 5; p++) begin
      load_prog(p);
      run_prog(20);
      foreach (vq[i]) begin
        if (vq[i].prog == p) check(vq[i].name, get_act(vq[i].kind, vq[i].idx), vq[i].exp);
      end
    end

    // Asynchronous reset asserted mid-run, while a store is in MEM
    load_prog(0);
    run_prog(5);
    @(negedge clk);
    check("rst_pre_we", {31'b0, data_we}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_inst_addr",  inst_addr,  32'd0);
    check("rst_data_we",    {31'b0, data_we}, 32'd0);
    check("rst_data_addr",  data_addr,  32'd0);
    check("rst_data_write", data_write, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rel_ia0", inst_addr, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("rel_ia%0d", k), inst_addr, 32'(4 * k));
    end

    // Random programs against the ISA model
    for (int t = 0; t < 20; t++) begin
      int n;
      n = int'($urandom_range(12, 30));
      gen_prog(n);
      run_model(n);
      run_prog(3 * n + 20);
      check($sformatf("rnd%0d_cnt", t), 32'(sa.size()), 32'(ea.size()));
      foreach (ea[i]) begin
        check($sformatf("rnd%0d_addr%0d", t, i), get_act(1, i), ea[i]);
        check($sformatf("rnd%0d_data%0d", t, i), get_act(2, i), ed[i]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
